// File: rtl/simple_counter_window_ctrl_pkg.sv
// simple_counter_ctrl_pkg: register offsets, bit positions and FSM encoding for the window controller
package simple_counter_ctrl_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_WINDOW = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;
  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int ST_BUSY       = 0;
  localparam int ST_DONE       = 1;
  localparam int ST_OVERRUN    = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAPTURE = 2'd2} state_t;
endpackage

// File: rtl/simple_counter_window_ctrl_if.sv
// simple_counter_window_ctrl_if: simple register access port from the AXI4-Lite slave
interface simple_counter_window_ctrl_if #(parameter int axi_addr_width = 32);
  logic [axi_addr_width-1:0] acc_waddr;
  logic [31:0]               acc_wdata;
  logic [3:0]                acc_wstrb;
  logic                      acc_wvalid;
  logic                      acc_wready;
  logic [axi_addr_width-1:0] acc_raddr;
  logic [31:0]               acc_rdata;
  logic                      acc_rvalid;
  logic                      acc_rready;
  modport master (output acc_waddr, acc_wdata, acc_wstrb, acc_wvalid, acc_raddr, acc_rvalid,
                  input acc_wready, acc_rdata, acc_rready);
  modport slave  (input acc_waddr, acc_wdata, acc_wstrb, acc_wvalid, acc_raddr, acc_rvalid,
                  output acc_wready, acc_rdata, acc_rready);
endinterface

// File: rtl/simple_counter_window_ctrl_window_timer.sv
// window_timer: 32-bit loadable down-counter that parks at zero and flags expiry
module window_timer (
  input  logic        clk,
  input  logic        srstn,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        expired
);
  logic [31:0] timer;
  // load takes priority; decrement saturates at zero so huge windows never wrap
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) timer <= '0;
    else if (load) timer <= load_val;
    else if (en && timer != '0) timer <= timer - 32'd1;
  assign expired = timer == '0;
endmodule

// File: rtl/simple_counter_window_ctrl.sv
// simple_counter_window_ctrl: measurement-window controller gating the write-data byte counter
module simple_counter_window_ctrl
  import simple_counter_ctrl_pkg::*;
#(
  parameter int axi_addr_width = 32,
  parameter int cnt_width      = 32
) (
  input  logic                 clk,
  input  logic                 srstn,
  simple_counter_window_ctrl_if.slave acc,
  input  logic [cnt_width-1:0] cnt_value,
  output logic                 cnt_enable,
  output logic                 done_irq
);
  state_t state, next_state;
  logic periodic, irq_en, done, overrun;
  logic [31:0] window;
  logic [15:0] period_cnt;
  logic [cnt_width-1:0] result;
  logic [1:0] wsel, rsel;
  logic wr_ctrl, wr_window, wr_status, start, stop;
  logic load, capture, clr_pcnt, expired;
  logic unused;
  assign wsel      = acc.acc_waddr[3:2];
  assign rsel      = acc.acc_raddr[3:2];
  assign wr_ctrl   = acc.acc_wvalid && wsel == REG_CTRL && acc.acc_wstrb[0];
  assign wr_window = acc.acc_wvalid && wsel == REG_WINDOW;
  assign wr_status = acc.acc_wvalid && wsel == REG_STATUS && acc.acc_wstrb[0];
  assign start     = wr_ctrl && acc.acc_wdata[CTRL_START];
  assign stop      = wr_ctrl && acc.acc_wdata[CTRL_STOP];
  assign acc.acc_wready = 1'b1;
  assign acc.acc_rready = 1'b1;
  assign cnt_enable = state == RUN;
  assign done_irq   = done && irq_en;
  assign unused = ^{acc.acc_waddr, acc.acc_raddr, acc.acc_rvalid, acc.acc_wdata, axi_addr_width == 0};
  window_timer u_timer (
    .clk      (clk),
    .srstn    (srstn),
    .load     (load),
    .load_val (window - 32'd1),
    .en       (state == RUN),
    .expired  (expired)
  );
  // state register
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) state <= IDLE;
    else state <= next_state;
  // next state plus the load/capture strobes; STOP always beats START and a periodic reload
  always_comb begin
    next_state = state;
    load       = 1'b0;
    capture    = 1'b0;
    clr_pcnt   = 1'b0;
    case (state)
      IDLE: begin
        load       = start && !stop && window != '0;
        clr_pcnt   = load;
        next_state = load ? RUN : IDLE;
      end
      RUN: next_state = stop ? IDLE : expired ? CAPTURE : RUN;
      CAPTURE: begin
        capture    = 1'b1;
        load       = periodic && !stop && window != '0;
        next_state = load ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
  // CTRL mode bits and byte-strobed WINDOW
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) begin
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      window   <= '0;
    end else begin
      if (wr_ctrl) begin
        periodic <= acc.acc_wdata[CTRL_PERIODIC];
        irq_en   <= acc.acc_wdata[CTRL_IRQ_EN];
      end
      for (int i = 0; i < 4; i++)
        if (wr_window && acc.acc_wstrb[i]) window[8*i +: 8] <= acc.acc_wdata[8*i +: 8];
    end
  // capture results and sticky status; a capture set wins over a same-cycle W1C
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) begin
      result     <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      period_cnt <= '0;
    end else begin
      if (capture) result <= cnt_value;
      done       <= capture ? 1'b1 : (wr_status && acc.acc_wdata[ST_DONE]) ? 1'b0 : done;
      overrun    <= (capture && done) ? 1'b1 : (wr_status && acc.acc_wdata[ST_OVERRUN]) ? 1'b0 : overrun;
      period_cnt <= clr_pcnt ? '0 : capture ? period_cnt + 16'd1 : period_cnt;
    end
  // combinational read mux
  always_comb
    acc.acc_rdata = rsel == REG_CTRL   ? {28'd0, irq_en, periodic, 2'b00} :
                    rsel == REG_WINDOW ? window :
                    rsel == REG_STATUS ? {period_cnt, 13'd0, overrun, done, state != IDLE} :
                    32'(result);
endmodule

// File: tb/tb_simple_counter_window_ctrl.sv
// tb_simple_counter_window_ctrl: directed register vectors plus hand-timed window sequences
module tb_simple_counter_window_ctrl;
  import simple_counter_ctrl_pkg::*;
  logic clk = 1'b0;
  logic srstn = 1'b0;
  logic [31:0] cnt_value, inc;
  logic cnt_enable, done_irq;
  int checks = 0, errors = 0, n;
  logic [8:0] pat;
  typedef struct {
    logic [1:0]  wreg;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  rreg;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];
  always #5 clk = ~clk;
  simple_counter_window_ctrl_if #(.axi_addr_width(32)) acc();
  simple_counter_window_ctrl #(.axi_addr_width(32), .cnt_width(32)) dut (
    .clk        (clk),
    .srstn      (srstn),
    .acc        (acc),
    .cnt_value  (cnt_value),
    .cnt_enable (cnt_enable),
    .done_irq   (done_irq)
  );
  // byte counter model: accumulates while enabled, clears when not
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) cnt_value <= '0;
    else cnt_value <= cnt_enable ? cnt_value + inc : '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    acc.acc_waddr  = {28'd0, r, 2'b00};
    acc.acc_wdata  = d;
    acc.acc_wstrb  = s;
    acc.acc_wvalid = 1'b1;
    @(negedge clk);
    acc.acc_wvalid = 1'b0;
  endtask
  task automatic rd_chk(input string name, input logic [1:0] r, input logic [31:0] exp);
    acc.acc_raddr  = {28'd0, r, 2'b00};
    acc.acc_rvalid = 1'b1;
    #1 chk(name, acc.acc_rdata, exp);
    acc.acc_rvalid = 1'b0;
  endtask
  initial begin
    acc.acc_waddr = '0; acc.acc_wdata = '0; acc.acc_wstrb = '0; acc.acc_wvalid = 1'b0;
    acc.acc_raddr = '0; acc.acc_rvalid = 1'b0;
    inc = 32'd0;
    vecs[0] = '{REG_WINDOW, 32'h12345678, 4'hF, REG_WINDOW, 32'h12345678};
    vecs[1] = '{REG_WINDOW, 32'hAABBCCDD, 4'h5, REG_WINDOW, 32'h12BB56DD};
    vecs[2] = '{REG_WINDOW, 32'hFFFFFFFF, 4'hA, REG_WINDOW, 32'hFFBBFFDD};
    vecs[3] = '{REG_CTRL,   32'h0000000C, 4'h1, REG_CTRL,   32'h0000000C};
    vecs[4] = '{REG_CTRL,   32'h000000F0, 4'h1, REG_CTRL,   32'h00000000};
    vecs[5] = '{REG_CTRL,   32'h0000000C, 4'h2, REG_CTRL,   32'h00000000};
    vecs[6] = '{REG_CTRL,   32'h00000003, 4'h1, REG_STATUS, 32'h00000000};
    vecs[7] = '{REG_STATUS, 32'hFFFFFFFF, 4'hF, REG_STATUS, 32'h00000000};
    vecs[8] = '{REG_RESULT, 32'hDEADBEEF, 4'hF, REG_RESULT, 32'h00000000};
    vecs[9] = '{REG_CTRL,   32'h0000000B, 4'h1, REG_CTRL,   32'h00000008};
    repeat (2) tick();
    srstn = 1'b1;
    chk("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    chk("rst_done_irq", {31'd0, done_irq}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rst_reg%0d", i), 2'(i), 32'd0);
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].wreg, vecs[i].wdata, vecs[i].wstrb);
      rd_chk($sformatf("vec%0d", i), vecs[i].rreg, vecs[i].exp);
    end
    wr(REG_WINDOW, 32'd0, 4'hF);
    wr(REG_CTRL, 32'h1, 4'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      n += int'(cnt_enable);
      tick();
    end
    chk("win0_enable_cycles", n, 0);
    rd_chk("win0_status", REG_STATUS, 32'd0);
    inc = 32'd16;
    wr(REG_WINDOW, 32'd4, 4'hF);
    wr(REG_CTRL, 32'h9, 4'h1);
    n = int'(cnt_enable);
    wr(REG_CTRL, 32'h9, 4'h1);
    n += int'(cnt_enable);
    wr(REG_WINDOW, 32'd6, 4'hF);
    n += int'(cnt_enable);
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(cnt_enable);
    end
    chk("w4_enable_cycles", n, 4);
    rd_chk("w4_result", REG_RESULT, 32'd64);
    rd_chk("w4_status", REG_STATUS, 32'h00010002);
    chk("w4_irq_on", {31'd0, done_irq}, 32'd1);
    rd_chk("w4_window_late", REG_WINDOW, 32'd6);
    wr(REG_CTRL, 32'h0, 4'h1);
    chk("w4_irq_off", {31'd0, done_irq}, 32'd0);
    wr(REG_STATUS, 32'h6, 4'h1);
    inc = 32'd4;
    wr(REG_WINDOW, 32'd3, 4'hF);
    wr(REG_CTRL, 32'h5, 4'h1);
    for (int i = 0; i < 9; i++) begin
      pat[i] = cnt_enable;
      if (i < 8) tick();
    end
    chk("per_enable_pattern", {23'd0, pat}, 32'h177);
    rd_chk("per_status", REG_STATUS, 32'h00020007);
    rd_chk("per_result", REG_RESULT, 32'd12);
    repeat (3) tick();
    chk("per_capture_gap", {31'd0, cnt_enable}, 32'd0);
    wr(REG_CTRL, 32'h6, 4'h1);
    chk("per_stop_en", {31'd0, cnt_enable}, 32'd0);
    rd_chk("per_stop_status", REG_STATUS, 32'h00030006);
    rd_chk("per_stop_result", REG_RESULT, 32'd12);
    tick();
    chk("per_stop_idle", {31'd0, cnt_enable}, 32'd0);
    inc = 32'd5;
    wr(REG_WINDOW, 32'd10, 4'hF);
    wr(REG_CTRL, 32'h1, 4'h1);
    repeat (4) tick();
    chk("abort_run5", {31'd0, cnt_enable}, 32'd1);
    wr(REG_CTRL, 32'h2, 4'h1);
    chk("abort_en", {31'd0, cnt_enable}, 32'd0);
    rd_chk("abort_result", REG_RESULT, 32'd12);
    rd_chk("abort_status", REG_STATUS, 32'h00000006);
    wr(REG_STATUS, 32'h6, 4'h1);
    rd_chk("w1c_both", REG_STATUS, 32'd0);
    inc = 32'd1;
    wr(REG_WINDOW, 32'd2, 4'hF);
    wr(REG_CTRL, 32'h9, 4'h1);
    repeat (2) tick();
    chk("race_capture", {31'd0, cnt_enable}, 32'd0);
    wr(REG_STATUS, 32'h2, 4'h1);
    rd_chk("race_status", REG_STATUS, 32'h00010002);
    chk("race_irq", {31'd0, done_irq}, 32'd1);
    rd_chk("race_result", REG_RESULT, 32'd2);
    wr(REG_STATUS, 32'h6, 4'h1);
    rd_chk("race_cleared", REG_STATUS, 32'h00010000);
    chk("race_irq_low", {31'd0, done_irq}, 32'd0);
    inc = 32'd7;
    wr(REG_WINDOW, 32'd1, 4'hF);
    wr(REG_CTRL, 32'h1, 4'h1);
    chk("w1_run", {31'd0, cnt_enable}, 32'd1);
    tick();
    chk("w1_capture", {31'd0, cnt_enable}, 32'd0);
    tick();
    rd_chk("w1_result", REG_RESULT, 32'd7);
    rd_chk("w1_status", REG_STATUS, 32'h00010002);
    inc = 32'd2;
    wr(REG_WINDOW, 32'd100, 4'hF);
    wr(REG_CTRL, 32'h1, 4'h1);
    repeat (3) tick();
    chk("rst_mid_run", {31'd0, cnt_enable}, 32'd1);
    #2 srstn = 1'b0;
    #1 chk("rst_async_drop", {31'd0, cnt_enable}, 32'd0);
    tick();
    srstn = 1'b1;
    chk("rst_after_en", {31'd0, cnt_enable}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rst2_reg%0d", i), 2'(i), 32'd0);
    chk("rst_after_irq", {31'd0, done_irq}, 32'd0);
    inc = 32'd3;
    wr(REG_WINDOW, 32'd2, 4'hF);
    wr(REG_CTRL, 32'h1, 4'h1);
    chk("post_rst_run", {31'd0, cnt_enable}, 32'd1);
    repeat (3) tick();
    rd_chk("post_rst_result", REG_RESULT, 32'd6);
    rd_chk("post_rst_status", REG_STATUS, 32'h00010002);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_counter_window_ctrl.md
Name: simple_counter_window_ctrl

Overview:
Measurement-window controller for the byte counter on the monitored write-data stream.
- Drives the counter's enable input; the counter clears whenever enable is low.
- Opens a programmable window of N clock cycles, captures the counter value at window close and raises a done interrupt.
- Runs one-shot or periodic.
- Register access comes from the AXI4-Lite slave interface's simple access port (acc_* signals).

Parameters:
- axi_addr_width, 32, width of acc_waddr/acc_raddr; only addr[3:2] are decoded.
- cnt_width, 32, width of cnt_value and the RESULT register.

Ports:
- clk  in  1  single clock for all logic.
- srstn  in  1  reset, asynchronous, active-low.
- acc_waddr  in  axi_addr_width  register write address.
- acc_wdata  in  32  register write data.
- acc_wstrb  in  4  write byte-lane enables.
- acc_wvalid  in  1  write request.
- acc_wready  out  1  write accept; tied 1.
- acc_raddr  in  axi_addr_width  register read address.
- acc_rdata  out  32  read data; combinational mux on acc_raddr.
- acc_rvalid  in  1  read request.
- acc_rready  out  1  read accept; tied 1.
- cnt_value  in  cnt_width  current counter value.
- cnt_enable  out  1  counter enable; low = counter clears at the next edge.
- done_irq  out  1  level interrupt = STATUS.done & CTRL.irq_en.

Behaviour:
Reset values:
- State IDLE, cnt_enable 0, done_irq 0.
- CTRL, WINDOW, RESULT, STATUS all 0.

Register map (addr[3:2]):
- 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 STOP (write-1 pulse, reads 0); bit2 PERIODIC (R/W); bit3 irq_en (R/W).
- 0x4 WINDOW: 32-bit cycle count, R/W, honours wstrb per byte.
- 0x8 STATUS: bit0 busy (RO); bit1 done (sticky, W1C); bit2 overrun (sticky, W1C); bits31:16 period_cnt (RO, wraps at 0xFFFF, cleared on START).
- 0xC RESULT: last captured cnt_value (RO).
- Writes to RO fields and unmapped bits are ignored. CTRL and STATUS use wstrb[0] only.

FSM states IDLE, RUN, CAPTURE:
- IDLE: cnt_enable=0.
  - START with WINDOW!=0 -> RUN, loading timer=WINDOW-1 and clearing period_cnt.
  - START with WINDOW==0 is ignored and the state stays IDLE.
- RUN: cnt_enable=1. The timer decrements each cycle.
  - timer==0 -> CAPTURE, so RUN lasts exactly WINDOW cycles.
  - STOP -> IDLE (abort); RESULT, done and period_cnt are unchanged.
- CAPTURE: exactly 1 cycle, cnt_enable=0.
  - RESULT<=cnt_value. This value includes every beat accepted during the RUN cycles; beats in the CAPTURE cycle are not counted.
  - period_cnt++; done<=1; overrun<=1 if done was already 1.
  - Next state is RUN (reload timer from the current WINDOW) if PERIODIC=1, no STOP seen and WINDOW!=0; otherwise IDLE.
  - The CAPTURE cycle doubles as the counter clear, giving a 1-cycle gap per period.

Boundary conditions:
- START while busy: ignored.
- START and STOP in the same write: STOP wins; a START from IDLE does nothing.
- STOP during CAPTURE: the capture completes, then the FSM goes to IDLE.
- A WINDOW write while busy affects only the next RUN load.
- Clearing PERIODIC while busy ends the run after the current window.
- W1C of done in the same cycle as a CAPTURE set: the set wins.
- WINDOW=1 gives a 1-cycle RUN. WINDOW=0xFFFFFFFF is legal with no wrap, because the timer is 32-bit and stops at 0.
- Asynchronous reset mid-RUN: cnt_enable drops immediately and all state returns to reset values.

Timing:
- done_irq rises the cycle after CAPTURE, since done is registered.
- Register write side-effects occur at the clock edge of the write; acc_rdata reflects them one cycle later.

Decomposition:
- Package simple_counter_ctrl_pkg holds:
  - register offsets REG_CTRL/REG_WINDOW/REG_STATUS/REG_RESULT;
  - CTRL/STATUS bit-position constants;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2).
- One sub-module, window_timer: load/decrement/expire logic, 32-bit down-counter with load, load_val, en and expired (timer==0) signals.

Test Plan:
1. WINDOW=4, START, bench counter adds 16 per cycle (full strobe, 128-bit beats, valid&ready every cycle) -> cnt_enable high for 4 cycles; RESULT=64; done=1; period_cnt=1; done_irq=1 only if irq_en=1; state IDLE.
2. WINDOW=0, START -> stays IDLE; cnt_enable stays 0; STATUS=0.
3. PERIODIC=1, WINDOW=3, beats with wstrb=0x000F every cycle -> RESULT=12 each period with a 1-cycle cnt_enable low gap. done not cleared before the second capture -> overrun=1, period_cnt=2. STOP -> IDLE after that period's CAPTURE if issued during CAPTURE, or immediately if issued during RUN.
4. WINDOW=10, START, STOP at RUN cycle 5 -> cnt_enable drops the next cycle; RESULT keeps its prior value; done unchanged.
5. Write STATUS=0x2 in the same cycle a CAPTURE sets done -> done reads 1. A later write of 0x6 -> done=0, overrun=0, done_irq=0.
6. Assert srstn low mid-RUN with WINDOW=100 -> cnt_enable=0 asynchronously; all registers read 0 after release; START works normally afterwards.
